// File: rtl/secuenciador_rampa_motor.sv
// ---------------------------------------------------------------------------
// secuenciador_rampa_motor
//
// Soft-start ramp sequencer for the motor driver stage.  The operator
// commands (Rapido, Lento, Parar) and the fault input (Falla) are arbitrated
// into a single target level.  The sequencer then walks the drive through
// 30 % -> 50 % -> 100 %, waiting a programmable dwell at each intermediate
// step.  The active drive level is presented as one-hot select lines.
//
// Optional build macro: SOFT_STOP_EN
//   When defined, a stop issued from 50 % or 100 % passes through a soft-stop
//   phase (BAJANDO) that holds 30 % drive for T_BAJA cycles before IDLE.
//   When undefined, every stop returns to IDLE at the next edge.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous reset, active low
//   Rapido    in   request full speed (target 100 %)
//   Lento     in   request slow speed (target 50 %)
//   Parar     in   request stop (target 0 %)
//   Falla     in   fault, level sensitive, highest priority
//   out_30    out  drive select 30 %
//   out_50    out  drive select 50 %
//   out_100   out  drive select 100 %
//   rampando  out  ramp in progress (S30, S50 heading to 100, BAJANDO)
//   listo     out  current level equals target level
//   estado    out  state code for debug/status
// ---------------------------------------------------------------------------
module secuenciador_rampa_motor #(
    parameter int CNT_W  = 16,
    parameter int T_30   = 1000,
    parameter int T_50   = 1000,
    parameter int T_BAJA = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rapido,
    input  logic       Lento,
    input  logic       Parar,
    input  logic       Falla,
    output logic       out_30,
    output logic       out_50,
    output logic       out_100,
    output logic       rampando,
    output logic       listo,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        S30     = 3'b001,
        S50     = 3'b010,
        S100    = 3'b011,
        BAJANDO = 3'b100,
        FALLA   = 3'b101
    } state_t;

    typedef enum logic [1:0] {
        TGT_0   = 2'd0,
        TGT_50  = 2'd1,
        TGT_100 = 2'd2
    } target_t;

    // Last count value of each dwell; the exit is taken on this value so the
    // counter never needs to go past it.
    localparam logic [CNT_W-1:0] LAST_30   = CNT_W'(T_30 - 1);
    localparam logic [CNT_W-1:0] LAST_50   = CNT_W'(T_50 - 1);
    localparam logic [CNT_W-1:0] LAST_BAJA = CNT_W'(T_BAJA - 1);

    state_t           state, state_next;
    target_t          target, target_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    state_t           stop_state;

    // State, target and dwell counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            target <= TGT_0;
            cnt    <= '0;
        end else begin
            state  <= state_next;
            target <= target_next;
            cnt    <= cnt_next;
        end
    end

    // Command arbitration: fault and stop force zero, full speed beats slow
    // speed, and with no command the previous target is kept.
    always_comb begin
        target_next = target;
        if (Falla || Parar) begin
            target_next = TGT_0;
        end else if (Rapido) begin
            target_next = TGT_100;
        end else if (Lento) begin
            target_next = TGT_50;
        end
    end

    // Where a stop from 50 % or 100 % lands.  A stop from 30 % always goes
    // straight to IDLE since the drive is already at the lowest step.
    always_comb begin
`ifdef SOFT_STOP_EN
        stop_state = BAJANDO;
`else
        stop_state = IDLE;
`endif
    end

    // Next-state logic.  The freshly arbitrated target is used so that a
    // command acts on the same edge it is sampled.  A fault overrides all.
    always_comb begin
        state_next = state;
        if (Falla) begin
            state_next = FALLA;
        end else begin
            unique case (state)
                IDLE: begin
                    if (target_next != TGT_0) state_next = S30;
                end
                S30: begin
                    if (target_next == TGT_0)  state_next = IDLE;
                    else if (cnt == LAST_30)   state_next = S50;
                end
                S50: begin
                    if (target_next == TGT_0)  state_next = stop_state;
                    else if (target_next == TGT_100 && cnt == LAST_50)
                        state_next = S100;
                end
                S100: begin
                    if (target_next == TGT_0)       state_next = stop_state;
                    else if (target_next == TGT_50) state_next = S50;
                end
                BAJANDO: begin
                    if (target_next != TGT_0)  state_next = S30;
                    else if (cnt == LAST_BAJA) state_next = IDLE;
                end
                FALLA: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Dwell counter: restarts on any state change.  In S50 it only runs while
    // heading for 100 %; parked at 50 % it stays at zero so a later Rapido
    // always gets the full 50 % dwell.
    always_comb begin
        cnt_next = '0;
        if (state_next == state) begin
            unique case (state)
                S30, BAJANDO: cnt_next = cnt + 1'b1;
                S50:          cnt_next = (target_next == TGT_100) ? cnt + 1'b1 : '0;
                default:      cnt_next = '0;
            endcase
        end
    end

    // Moore output decode from the registered state and target.
    always_comb begin
        estado   = state;
        out_30   = (state == S30) || (state == BAJANDO);
        out_50   = (state == S50);
        out_100  = (state == S100);
        rampando = (state == S30) || (state == BAJANDO) ||
                   (state == S50 && target == TGT_100);
        listo    = (state == IDLE && target == TGT_0)  ||
                   (state == S50  && target == TGT_50) ||
                   (state == S100 && target == TGT_100);
    end

endmodule

// File: tb/tb_secuenciador_rampa_motor.sv
// ---------------------------------------------------------------------------
// tb_secuenciador_rampa_motor
//
// Self-checking bench for secuenciador_rampa_motor.  A behavioural model
// tracks the drive level in percent, the target in percent and the number of
// cycles spent at the current level, and predicts every output each cycle.
// Directed sequences walk the ramp scenarios, then randomized commands and
// occasional asynchronous resets exercise arbitrary interleavings.
// ---------------------------------------------------------------------------
module tb_secuenciador_rampa_motor;

    localparam int T_30   = 4;
    localparam int T_50   = 3;
    localparam int T_BAJA = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Rapido = 1'b0;
    logic       Lento = 1'b0;
    logic       Parar = 1'b0;
    logic       Falla = 1'b0;
    logic       out_30, out_50, out_100, rampando, listo;
    logic [2:0] estado;

    int checks = 0;
    int errors = 0;

    // Model state: level in percent, target in percent, cycles at level.
    int m_level  = 0;
    int m_target = 0;
    int m_dwell  = 0;
    bit m_fault  = 1'b0;
    bit m_soft   = 1'b0;

    secuenciador_rampa_motor #(
        .CNT_W (16),
        .T_30  (T_30),
        .T_50  (T_50),
        .T_BAJA(T_BAJA)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .Rapido  (Rapido),
        .Lento   (Lento),
        .Parar   (Parar),
        .Falla   (Falla),
        .out_30  (out_30),
        .out_50  (out_50),
        .out_100 (out_100),
        .rampando(rampando),
        .listo   (listo),
        .estado  (estado)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_level  = 0;
        m_target = 0;
        m_dwell  = 0;
        m_fault  = 1'b0;
        m_soft   = 1'b0;
    endtask

    // A stop from 50 % or 100 %.
    task automatic modelStop();
`ifdef SOFT_STOP_EN
        m_level = 30;
        m_soft  = 1'b1;
`else
        m_level = 0;
`endif
        m_dwell = 0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic modelStep(input bit r, input bit l, input bit p, input bit f);
        int nt;
        if (f || p)  nt = 0;
        else if (r)  nt = 100;
        else if (l)  nt = 50;
        else         nt = m_target;

        if (f) begin
            m_fault = 1'b1;
            m_soft  = 1'b0;
            m_level = 0;
            m_dwell = 0;
        end else if (m_fault) begin
            m_fault = 1'b0;
            m_level = 0;
            m_dwell = 0;
        end else if (m_soft) begin
            if (nt != 0) begin
                m_soft  = 1'b0;
                m_level = 30;
                m_dwell = 0;
            end else begin
                m_dwell++;
                if (m_dwell == T_BAJA) begin
                    m_soft  = 1'b0;
                    m_level = 0;
                    m_dwell = 0;
                end
            end
        end else begin
            case (m_level)
                0: begin
                    if (nt != 0) begin
                        m_level = 30;
                        m_dwell = 0;
                    end
                end
                30: begin
                    if (nt == 0) begin
                        m_level = 0;
                        m_dwell = 0;
                    end else begin
                        m_dwell++;
                        if (m_dwell == T_30) begin
                            m_level = 50;
                            m_dwell = 0;
                        end
                    end
                end
                50: begin
                    if (nt == 0) modelStop();
                    else if (nt == 50) m_dwell = 0;
                    else begin
                        m_dwell++;
                        if (m_dwell == T_50) begin
                            m_level = 100;
                            m_dwell = 0;
                        end
                    end
                end
                default: begin
                    if (nt == 0) modelStop();
                    else if (nt == 50) begin
                        m_level = 50;
                        m_dwell = 0;
                    end
                end
            endcase
        end
        m_target = nt;
    endtask

    // Compare every output with the model's prediction.
    task automatic compareAll(input string tag);
        int code;
        bit e_ramp, e_listo;
        if (m_fault)            code = 5;
        else if (m_soft)        code = 4;
        else if (m_level == 30) code = 1;
        else if (m_level == 50) code = 2;
        else if (m_level == 100) code = 3;
        else                    code = 0;
        e_ramp  = (m_level == 30) || (m_level == 50 && m_target == 100);
        e_listo = !m_fault && !m_soft && (m_level == m_target);
        checkOutput({tag, "_estado"}, {5'd0, estado}, 8'(code));
        checkOutput({tag, "_outs"}, {5'd0, out_100, out_50, out_30},
                    {5'd0, m_level == 100, m_level == 50, m_level == 30});
        checkOutput({tag, "_rampando"}, {7'd0, rampando}, {7'd0, e_ramp});
        checkOutput({tag, "_listo"}, {7'd0, listo}, {7'd0, e_listo});
    endtask

    // Drive one cycle of commands, advance one edge, then check.
    task automatic applyStimulus(input string tag, input bit r, input bit l,
                                 input bit p, input bit f);
        Rapido = r;
        Lento  = l;
        Parar  = p;
        Falla  = f;
        @(posedge clk);
        modelStep(r, l, p, f);
        #1;
        compareAll(tag);
    endtask

    // Assert reset between edges and confirm outputs clear with no edge.
    task automatic asyncReset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        compareAll(tag);
        checkOutput({tag, "_drive_off"}, {5'd0, out_100, out_50, out_30}, 8'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // Reset held low.
        repeat (3) @(posedge clk);
        #1;
        modelReset();
        compareAll("rst");
        checkOutput("rst_estado_const", {5'd0, estado}, 8'd0);
        checkOutput("rst_listo_const", {7'd0, listo}, 8'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) applyStimulus("idle", 0, 0, 0, 0);

        // Full ramp from a single Rapido pulse.
        applyStimulus("ramp", 1, 0, 0, 0);
        repeat (9) applyStimulus("ramp", 0, 0, 0, 0);
        checkOutput("ramp_at100", {5'd0, estado}, 8'd3);

        // Back to idle, then Lento held, then Rapido pulse.
        applyStimulus("stop", 0, 0, 1, 0);
        repeat (7) applyStimulus("stop", 0, 0, 0, 0);
        repeat (24) applyStimulus("lento", 0, 1, 0, 0);
        checkOutput("lento_at50", {6'd0, out_50, listo}, 8'd3);
        applyStimulus("up", 1, 0, 0, 0);
        repeat (4) applyStimulus("up", 0, 0, 0, 0);

        // Downshift from 100 and stop.
        applyStimulus("down", 0, 1, 0, 0);
        checkOutput("down_at50", {7'd0, out_50}, 8'd1);
        applyStimulus("down", 0, 0, 1, 0);
        repeat (7) applyStimulus("down", 0, 0, 0, 0);

        // Fault in S30 with Rapido held.
        applyStimulus("fault", 1, 0, 0, 0);
        repeat (2) applyStimulus("fault", 1, 0, 0, 0);
        repeat (3) applyStimulus("fault", 1, 0, 0, 1);
        checkOutput("fault_code", {5'd0, estado}, 8'd5);
        repeat (3) applyStimulus("fault", 1, 0, 0, 0);

        // Conflicting commands, then asynchronous reset in S50.
        applyStimulus("conf", 0, 0, 1, 0);
        repeat (7) applyStimulus("conf", 0, 0, 0, 0);
        applyStimulus("conf", 1, 0, 1, 0);
        checkOutput("conf_idle", {5'd0, estado}, 8'd0);
        applyStimulus("both", 1, 1, 0, 0);
        repeat (9) applyStimulus("both", 0, 0, 0, 0);
        applyStimulus("both", 0, 1, 0, 0);
        asyncReset("arst");

        // Randomized commands with occasional asynchronous reset.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                asyncReset("rnd_rst");
            end else begin
                applyStimulus("rnd",
                              $urandom_range(0, 7) == 0,
                              $urandom_range(0, 7) == 0,
                              $urandom_range(0, 14) == 0,
                              $urandom_range(0, 19) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
